// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and defaults for the SDRAM command-port arbiter
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 32;
    localparam int NREQ_MAX   = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting the search at ptr
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && req[(int'(ptr) + i) % NREQ]) begin
                any = 1'b1;
                grant[(int'(ptr) + i) % NREQ] = 1'b1;
                idx = PTR_W'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin sharing of the single SDRAM controller command port
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ack,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     mem_enable,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic                     busy,
    output logic                     err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int PTR_W = $clog2(NREQ_MAX);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              mem_enable_d, mem_write_d, busy_d, err_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d, req_rdata_d;
    logic [NREQ-1:0]   req_ack_d;

    logic [NREQ-1:0]   pick_grant;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (mem_ready && pick_any) state_d = ISSUE;
            ISSUE: begin
                if (!mem_ready) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = ACK;
                end
            end
            WAIT_DONE: if (mem_ready) state_d = ACK;
            ACK:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Next values of every registered output; the register block below only samples them.
    always_comb begin
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        cnt_d        = cnt_q;
        mem_enable_d = mem_enable;
        mem_write_d  = mem_write;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        req_rdata_d  = req_rdata;
        err_d        = err;
        case (state_q)
            IDLE: begin
                if (mem_ready && pick_any) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick_grant[i]) begin
                            mem_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            mem_wdata_d = req_wdata[i*DATA_W +: DATA_W];
                            mem_write_d = req_write[i];
                        end
                    end
                    mem_enable_d = 1'b1;
                    gnt_d        = pick_grant;
                    ptr_d        = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    cnt_d        = '0;
                end
            end
            ISSUE: begin
                if (!mem_ready) begin
                    mem_enable_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_enable_d = 1'b0;
                    err_d        = 1'b1;
                    cnt_d        = CNT_W'(TIMEOUT);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (mem_ready && !mem_write) req_rdata_d = mem_rdata;
            end
            default: ;
        endcase
        req_ack_d = (state_d == ACK) ? gnt_q : '0;
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            cnt_q      <= '0;
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            req_rdata  <= '0;
            req_ack    <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            mem_enable <= mem_enable_d;
            mem_write  <= mem_write_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            req_rdata  <= req_rdata_d;
            req_ack    <= req_ack_d;
            busy       <= busy_d;
            err        <= err_d;
        end
    end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Round-robin arbiter that shares the single SDRAM controller command port (enable/write/addr/write_data, read_data/ready) between up to four internal requesters. Sits between the requesters (test sequencer, LED/status logic, future DMA) and the `sdram` controller, in the same clock domain as the controller's `clk`. Each requester gets a simple valid/ack transaction interface; the arbiter serialises transactions and issues one controller command at a time.

## Interface
- NREQ, 2: number of requesters, legal 2..4
- ADDR_W, 24: controller word address width
- DATA_W, 32: data width
- TIMEOUT, 255: max cycles in ISSUE waiting for `mem_ready` to drop; legal 1..65535
- clk  in  1  system clock; same clock as the SDRAM controller
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  request pending per requester; held until its `req_ack`
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  per-requester write data, same packing
- req_ack  out  NREQ  one-cycle completion pulse, one-hot or zero
- req_rdata  out  DATA_W  read data, valid in the `req_ack` cycle, held until next ack
- mem_enable  out  1  controller command request
- mem_write  out  1  controller write select
- mem_addr  out  ADDR_W  controller address
- mem_wdata  out  DATA_W  controller write data
- mem_rdata  in  DATA_W  controller read data, valid when `mem_ready` returns high
- mem_ready  in  1  controller idle/complete
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky: a TIMEOUT occurred; cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT_DONE, ACK.
- IDLE: if `mem_ready`=1 and any `req_valid`, pick winner g by round robin starting at `ptr`; register `mem_addr`/`mem_write`/`mem_wdata` from requester g; `mem_enable`<=1; `ptr`<=(g+1) mod NREQ; go to ISSUE. If `mem_ready`=0, stay in IDLE and grant nothing.
- ISSUE: hold `mem_enable`=1 and all mem_* fields stable. On `mem_ready`=0, set `mem_enable`<=0 and go to WAIT_DONE. If the counter reaches TIMEOUT without `mem_ready` dropping, set `mem_enable`<=0 and `err`<=1, then go to ACK with `req_rdata` unchanged.
- WAIT_DONE: on `mem_ready`=1, capture `req_rdata`<=`mem_rdata` (reads only; writes leave `req_rdata` unchanged) and go to ACK. No timeout in this state.
- ACK: `req_ack[g]`=1 for exactly this cycle, then go to IDLE.
- Round robin: `ptr` resets to 0. A requester that just completed has the lowest priority at the next grant. Single active requester: back-to-back service. All NREQ active: strict rotation 0,1,..,NREQ-1.
- `req_valid[i]` dropping before its ack is a protocol violation. A non-granted requester's inputs are ignored. A granted transaction is not cancelled.
- A `req_valid` still high in the cycle after ack is a new request.

## Timing
- Reset (async assert, sync release): state IDLE, `mem_enable`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, `req_ack`=0, `req_rdata`=0, `busy`=0, `err`=0, `ptr`=0, timeout counter 0. Reset mid-transaction drops `mem_enable` immediately. The controller is reset from the same source.
- All outputs are registered. `mem_enable` rises 1 cycle after IDLE sees valid && `mem_ready`.
- Minimum transaction: grant (1) + ISSUE until `mem_ready` drops (≥1) + WAIT_DONE (≥1) + ACK (1) = 4 cycles from `req_valid` to `req_ack`. Next grant at the earliest in the cycle after ACK.
- The timeout counter is cleared on entry to ISSUE and counts ISSUE cycles. It saturates at TIMEOUT; width is clog2(TIMEOUT+1).

## Structure
- Package `sdram_arb_pkg`: ADDR_W/DATA_W defaults, state enum (IDLE, ISSUE, WAIT_DONE, ACK), NREQ_MAX=4.
- Sub-module `rr_pick`: combinational round-robin picker (inputs: request vector, ptr; outputs: one-hot grant, index, any). It is the only sub-module; the FSM and datapath registers stay in `sdram_arbiter`.

## Test plan
- Reset with `mem_ready`=1, `req_valid`=0 -> all outputs 0, `busy`=0; asserting `rst_n`=0 during ISSUE drops `mem_enable` without waiting for a clock.
- Single read by requester 1, addr 24'h000010, behavioural controller returns 32'hDEADBEEF after 5 busy cycles -> `mem_addr`=24'h000010, `mem_write`=0, one `req_ack`=2'b10 pulse, `req_rdata`=32'hDEADBEEF.
- Write by requester 0, data 32'hFFFFFFFF, then read same address -> read returns 32'hFFFFFFFF; `req_rdata` unchanged across the write ack.
- NREQ=4, all valid continuously, 8 transactions -> grant order 0,1,2,3,0,1,2,3; each requester acked exactly twice.
- `mem_ready` held 0 at request time for 10 cycles -> no `mem_enable` until it rises; then normal transaction.
- TIMEOUT=4, controller never drops `mem_ready` -> `mem_enable` high 4 cycles then low, `err`=1 sticky, `req_ack` pulses, next request still served.
